// File: rtl/lcd_seq_pkg.sv
// Shared opcode values, sequencer state encoding and the opcode legality check
// for the LCD_CTRL command sequencer.
package lcd_seq_pkg;

    localparam logic [3:0] OP_WRITE    = 4'd0;
    localparam logic [3:0] OP_SH_UP    = 4'd1;
    localparam logic [3:0] OP_SH_DOWN  = 4'd2;
    localparam logic [3:0] OP_SH_LEFT  = 4'd3;
    localparam logic [3:0] OP_SH_RIGHT = 4'd4;
    localparam logic [3:0] OP_MAXV     = 4'd5;
    localparam logic [3:0] OP_MINV     = 4'd6;
    localparam logic [3:0] OP_AVG      = 4'd7;
    localparam logic [3:0] OP_ROT_CCW  = 4'd8;
    localparam logic [3:0] OP_ROT_CW   = 4'd9;
    localparam logic [3:0] OP_MIRROR_X = 4'd10;
    localparam logic [3:0] OP_MIRROR_Y = 4'd11;
    localparam logic [3:0] OP_MAX      = 4'd11;

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StWaitDone,
        StFault
    } seq_state_e;

    function automatic logic is_legal(input logic [3:0] op);
        return op <= OP_MAX;
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous opcode FIFO; flush dominates push and pop, pushes when full
// and pops when empty are ignored.
module lcd_cmd_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned DW    = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [DW-1:0]          data_i,
    output logic [DW-1:0]          data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign level_o = cnt_q;
    assign data_o  = mem_q[rptr_q];
    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (do_push) wptr_d = wptr_q + AW'(1);
            if (do_pop)  rptr_d = rptr_q + AW'(1);
            cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Host-side command scheduler for LCD_CTRL: queues opcodes and issues them one
// at a time, honouring busy, waiting on done after a Write and watching for hangs.
module lcd_cmd_sequencer
    import lcd_seq_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned HOLDOFF = 1,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   en_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [3:0]             push_cmd_i,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic [3:0]             cmd_o,
    output logic                   cmd_valid_o,
    input  logic                   busy_i,
    input  logic                   done_i,
    output logic                   seq_done_o,
    output logic                   timeout_o,
    output logic                   illegal_o,
    output logic                   overflow_o,
    output logic [CNT_W-1:0]       issued_o
);

    localparam int unsigned HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    seq_state_e       state_q, state_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [WW-1:0]    wd_q, wd_d;
    logic [3:0]       cmd_q, cmd_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic             seq_done_q, seq_done_d;
    logic             timeout_q, timeout_d;
    logic             illegal_q, illegal_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] issued_q, issued_d;

    logic       pop;
    logic [3:0] head;
    logic       fifo_empty;
    logic       fifo_full;

    lcd_cmd_fifo #(
        .DEPTH (DEPTH),
        .DW    (4)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (push_i),
        .pop_i   (pop),
        .data_i  (push_cmd_i),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level_o)
    );

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        wd_d        = wd_q;
        cmd_d       = cmd_q;
        cmd_valid_d = 1'b0;
        seq_done_d  = 1'b0;
        timeout_d   = timeout_q;
        illegal_d   = illegal_q;
        overflow_d  = overflow_q;
        issued_d    = issued_q;
        pop         = 1'b0;

        if (flush_i) begin
            state_d    = StIdle;
            hold_d     = '0;
            wd_d       = '0;
            timeout_d  = 1'b0;
            illegal_d  = 1'b0;
            overflow_d = 1'b0;
        end else begin
            if (push_i && fifo_full) overflow_d = 1'b1;

            unique case (state_q)
                StIdle: begin
                    if (en_i && !fifo_empty && !busy_i) begin
                        pop = 1'b1;
                        if (is_legal(head)) begin
                            cmd_d       = head;
                            cmd_valid_d = 1'b1;
                            if (issued_q != '1) issued_d = issued_q + CNT_W'(1);
                            hold_d      = HW'(HOLDOFF);
                            state_d     = StHold;
                        end else begin
                            illegal_d = 1'b1;
                        end
                    end
                end
                StHold: begin
                    // cmd_q still holds the opcode just issued.
                    if (hold_q == '0) begin
                        wd_d    = '0;
                        state_d = (cmd_q == OP_WRITE) ? StWaitDone : StIdle;
                    end else begin
                        hold_d = hold_q - HW'(1);
                    end
                end
                StWaitDone: begin
                    if (done_i) begin
                        seq_done_d = 1'b1;
                        state_d    = StIdle;
                    end else if (wd_q == WW'(TIMEOUT - 1)) begin
                        timeout_d = 1'b1;
                        state_d   = StFault;
                    end else begin
                        wd_d = wd_q + WW'(1);
                    end
                end
                StFault: begin
                    state_d = StFault;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            hold_q      <= '0;
            wd_q        <= '0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            seq_done_q  <= 1'b0;
            timeout_q   <= 1'b0;
            illegal_q   <= 1'b0;
            overflow_q  <= 1'b0;
            issued_q    <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            wd_q        <= wd_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            seq_done_q  <= seq_done_d;
            timeout_q   <= timeout_d;
            illegal_q   <= illegal_d;
            overflow_q  <= overflow_d;
            issued_q    <= issued_d;
        end
    end

    assign full_o      = fifo_full;
    assign cmd_o       = cmd_q;
    assign cmd_valid_o = cmd_valid_q;
    assign seq_done_o  = seq_done_q;
    assign timeout_o   = timeout_q;
    assign illegal_o   = illegal_q;
    assign overflow_o  = overflow_q;
    assign issued_o    = issued_q;

endmodule
